chien_ctrl: RTL and testbench
=============================

Name: chien_ctrl

Overview:
- Sequencer for one `chien` search instance (M, T, sigma bus of M*(T+1) bits).
- Accepts an error-locator polynomial from the key-equation solver over a valid/ready handshake.
- Loads the search registers with `ch_start`, then steps them with `cei` under downstream backpressure, so each codeword position is emitted with its error flag.
- Ends each search with a summary: error count, plus an uncorrectable flag when the root count differs from the polynomial degree.

Parameters:
- M, 4, field width (GF(2^M)).
- T, 3, correction capability; sigma carries T+1 coefficients, coefficient i at bits [i*M +: M].
- N, 15, positions searched (shortened codes allowed); 1 <= N <= 2^M-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_sigma  in  M*(T+1)  locator coefficients.
- in_valid  in  1  in_sigma valid.
- in_ready  out  1  controller can accept a polynomial.
- ch_sigma  out  M*(T+1)  registered coefficients to the search datapath.
- ch_start  out  1  load pulse to the search datapath.
- cei  out  1  step enable to the search datapath.
- ch_err  in  1  error flag from the search datapath, combinational from its registers.
- out_valid  out  1  position result valid.
- out_ready  in  1  downstream accepts position.
- out_err  out  1  position is in error.
- out_idx  out  clog2(N)  position index j; evaluation point alpha^j.
- done_valid  out  1  summary valid.
- done_ready  in  1  summary accepted.
- done_count  out  clog2(N+1)  roots found.
- done_fail  out  1  done_count != degree(sigma).

Behaviour:
- Reset (asynchronous, rst_n low) forces state IDLE and clears every register. All outputs read 0 during reset, including in_ready, ch_sigma, ch_start and cei.
- FSM states: IDLE, LOAD, SEARCH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register in_sigma into ch_sigma.
  - Register deg = index of the highest nonzero coefficient; deg=0 if all coefficients are zero.
  - Clear idx and count, then go to LOAD.
- LOAD:
  - Exactly one cycle with ch_start=1, cei=0.
  - in_ready=0 in every state except IDLE.
  - Next state SEARCH.
- SEARCH:
  - out_valid=1, out_err=ch_err (combinational passthrough), out_idx=idx.
  - cei = out_ready; the datapath advances only on a handshake.
  - On handshake: count += ch_err, idx += 1.
  - If idx==N-1 at the handshake, go to DONE.
  - out_valid stalled with out_ready=0: out_err and out_idx hold, cei=0.
- DONE:
  - done_valid=1, done_count=count, done_fail=(count!=deg).
  - On done_ready, go to IDLE.
  - out_valid=0, cei=0.
- Latency: acceptance at cycle c gives ch_start at c+1 and the first out_valid at c+2. Throughput is N+3 cycles per polynomial when neither output port stalls.
- Count saturates at N; it cannot exceed N by construction.
- All-zero sigma: ch_err stays 1 at every position, so done_count=N and done_fail=1.
- deg=0 with sigma0!=0: no roots, so count=0 and fail=0.
- ch_sigma holds its value after LOAD until the next acceptance.
- ch_start and cei are never asserted in the same cycle.

Optional Feature:
- Macro: CHIEN_CTRL_EARLY_EXIT_EN.
- When defined: in SEARCH, a handshake that makes count+ch_err equal deg, with deg>0, goes directly to DONE. Remaining positions are not emitted, and done_fail is evaluated as normal (0).
- When undefined: all N positions are always emitted.

Decomposition:
- Shared package:
  - FSM state encoding.
  - Width helpers (clog2 for idx and count).
  - The degree function (highest nonzero M-bit slice of a T+1 coefficient vector).
- One natural sub-module: `chien_deg`, a combinational degree finder. The FSM, counters and handshake stay in `chien_ctrl`.
- The `chien` instance sits outside; the integration wrapper connects ch_* ports to it.

Test Plan:
All cases use M=4, T=3, N=15, field polynomial x^4+x+1, and the real `chien` instance.
- Single error: sigma={0,0,4'hF,1} (sigma1=alpha^12), out_ready=1.
  - out_err=1 only at idx=3; 15 position beats.
  - done_count=1, done_fail=0; first out_valid exactly 2 cycles after acceptance.
- No error: sigma={0,0,0,1}.
  - 15 beats, all out_err=0.
  - done_count=0, done_fail=0.
- Backpressure: single-error sigma with out_ready toggling randomly.
  - cei only on handshakes; out_idx/out_err stable while stalled.
  - Same positions and summary as the unstalled run.
- Degree mismatch: sigma={0,1,0,1} (x^2+1 = (x+1)^2, one distinct root at alpha^0).
  - out_err at idx=0 only; done_count=1, deg=2, done_fail=1.
- Async reset mid-SEARCH at idx=7:
  - all outputs 0 immediately.
  - after release, in_ready=1; next polynomial processed from idx=0.
- Early exit (macro defined): single-error sigma.
  - last beat idx=3, then DONE with count=1, fail=0.
  - with the macro undefined, the same stimulus gives 15 beats.

Source files
------------

// File: rtl/chien_ctrl_pkg.sv
// Shared definitions for the Chien search sequencer: FSM encoding, width helpers
// and the locator-degree function used by chien_deg.
// Latency: n/a (types and constant functions only). Backpressure: n/a.
package chien_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SEARCH = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // The degree function works on a fixed-width container so it can be shared
    // by any (M, T) whose sigma bus fits in it.
    localparam int unsigned SIGMA_MAX_W = 64;
    localparam int unsigned MAX_COEF    = 16;

    // Width of a position index 0..n-1 (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width of a root counter 0..n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width of a degree value 0..t.
    function automatic int unsigned deg_w(input int unsigned t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

    // Index of the highest nonzero m-bit coefficient among t+1; 0 when all are zero.
    function automatic int unsigned sigma_deg(input logic [SIGMA_MAX_W-1:0] sig,
                                              input int unsigned m,
                                              input int unsigned t);
        logic [SIGMA_MAX_W-1:0] mask;
        int unsigned            d;
        mask = (SIGMA_MAX_W'(1) << m) - SIGMA_MAX_W'(1);
        d    = 0;
        for (int unsigned i = 0; i < MAX_COEF; i++) begin
            if ((i <= t) && (((sig >> (i * m)) & mask) != '0)) begin
                d = i;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/chien_ctrl_deg.sv
// chien_deg: combinational degree finder for an error-locator polynomial.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: i_sigma (M*(T+1) coefficients, coef i at [i*M +: M]) -> o_deg (0..T).
module chien_deg
    import chien_ctrl_pkg::*;
#(
    parameter int unsigned M = 4,
    parameter int unsigned T = 3
) (
    input  logic [M*(T+1)-1:0]  i_sigma,
    output logic [deg_w(T)-1:0] o_deg
);

    localparam int unsigned DW = deg_w(T);

    logic [SIGMA_MAX_W-1:0] w_sig_ext;

    assign w_sig_ext = SIGMA_MAX_W'(i_sigma);
    assign o_deg     = DW'(sigma_deg(w_sig_ext, M, T));

endmodule

// File: rtl/chien_ctrl.sv
// chien_ctrl: sequencer for one Chien search instance (load, step, summarise).
// Latency: accept at c -> ch_start at c+1 -> first position at c+2; N+3 cycles/poly unstalled.
// Backpressure: cei follows out_ready so the datapath only advances on a position handshake;
// the summary is held until done_ready.
// Ports: in_* polynomial input (valid/ready), ch_* search datapath drive/return,
// out_* per-position results (valid/ready), done_* per-search summary (valid/ready).
// Optional: CHIEN_CTRL_EARLY_EXIT_EN ends the search once the root count reaches deg > 0.
module chien_ctrl
    import chien_ctrl_pkg::*;
#(
    parameter int unsigned M = 4,
    parameter int unsigned T = 3,
    parameter int unsigned N = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [M*(T+1)-1:0]    in_sigma,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [M*(T+1)-1:0]    ch_sigma,
    output logic                  ch_start,
    output logic                  cei,
    input  logic                  ch_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_err,
    output logic [idx_w(N)-1:0]   out_idx,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [cnt_w(N)-1:0]   done_count,
    output logic                  done_fail
);

    localparam int unsigned SW = M * (T + 1);
    localparam int unsigned IW = idx_w(N);
    localparam int unsigned CW = cnt_w(N);
    localparam int unsigned DW = deg_w(T);

    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(N);

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_count;
    logic [DW-1:0]   r_deg;
    logic [SW-1:0]   r_sigma;

    logic [DW-1:0]   w_deg;
    logic            w_accept;
    logic            w_out_hs;
    logic            w_early;
    logic [CW-1:0]   w_count_nxt;

    chien_deg #(
        .M (M),
        .T (T)
    ) u_deg (
        .i_sigma (in_sigma),
        .o_deg   (w_deg)
    );

    assign w_accept    = in_valid && in_ready;
    assign w_out_hs    = out_valid && out_ready;
    // Saturating count; N positions can never produce more than N roots anyway.
    assign w_count_nxt = (ch_err && (r_count != CNT_MAX)) ? r_count + CW'(1) : r_count;

`ifdef CHIEN_CTRL_EARLY_EXIT_EN
    // Once every root the degree promises has been found the rest are known clean.
    assign w_early = (r_deg != '0) && (32'(w_count_nxt) == 32'(r_deg));
`else
    assign w_early = 1'b0;
`endif

    assign ch_sigma   = r_sigma;
    assign out_idx    = r_idx;
    assign done_count = r_count;

    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        ch_start   = 1'b0;
        cei        = 1'b0;
        out_valid  = 1'b0;
        out_err    = 1'b0;
        done_valid = 1'b0;
        done_fail  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Gated by rst_n so in_ready reads 0 while reset is held.
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ch_start = 1'b1;
                w_next   = ST_SEARCH;
            end
            ST_SEARCH: begin
                out_valid = 1'b1;
                out_err   = ch_err;
                cei       = out_ready;
                if (out_ready && ((r_idx == IDX_LAST) || w_early)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_valid = 1'b1;
                done_fail  = (32'(r_count) != 32'(r_deg));
                if (done_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_count <= '0;
            r_deg   <= '0;
            r_sigma <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_sigma <= in_sigma;
                r_deg   <= w_deg;
                r_idx   <= '0;
                r_count <= '0;
            end else if (w_out_hs) begin
                r_count <= w_count_nxt;
                if (r_idx != IDX_LAST) begin
                    r_idx <= r_idx + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_chien_ctrl.sv
module tb_chien_ctrl;

    localparam int M = 4;
    localparam int T = 3;
    localparam int N = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_sigma;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ch_sigma;
    logic        ch_start;
    logic        cei;
    logic        ch_err;
    logic        out_valid;
    logic        out_ready;
    logic        out_err;
    logic [3:0]  out_idx;
    logic        done_valid;
    logic        done_ready;
    logic [3:0]  done_count;
    logic        done_fail;

    int n_asrt = 0;
    int n_fail = 0;

    typedef struct packed { logic [3:0] idx; logic err; } beat_t;
    typedef struct packed { logic [3:0] cnt; logic fail; } sum_t;
    beat_t exp_q[$];
    sum_t  sum_q[$];

    always #5 clk = ~clk;

    chien_ctrl #(.M(M), .T(T), .N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_sigma   (in_sigma),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ch_sigma   (ch_sigma),
        .ch_start   (ch_start),
        .cei        (cei),
        .ch_err     (ch_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_err    (out_err),
        .out_idx    (out_idx),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_count (done_count),
        .done_fail  (done_fail)
    );

    // GF(2^4) arithmetic, field polynomial x^4+x+1, alpha = 2.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [3:0] apow(input int k);
        logic [3:0] r;
        r = 4'h1;
        for (int i = 0; i < k; i++) r = gf_mul(r, 4'h2);
        return r;
    endfunction

    // Direct evaluation sigma(alpha^j) by Horner's rule.
    function automatic logic [3:0] eval_at(input logic [15:0] s, input int j);
        logic [3:0] x;
        logic [3:0] acc;
        x   = apow(j);
        acc = 4'h0;
        for (int i = 3; i >= 0; i--) acc = gf_mul(acc, x) ^ s[i*4 +: 4];
        return acc;
    endfunction

    // Behavioural Chien datapath: register i holds sigma_i * alpha^(i*j).
    logic [3:0] dp [4];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) dp[i] <= 4'h0;
        end else if (ch_start) begin
            for (int i = 0; i < 4; i++) dp[i] <= ch_sigma[i*4 +: 4];
        end else if (cei) begin
            for (int i = 0; i < 4; i++) dp[i] <= gf_mul(dp[i], apow(i));
        end
    end
    assign ch_err = ((dp[0] ^ dp[1] ^ dp[2] ^ dp[3]) == 4'h0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push the expected beats and summary for one polynomial.
    task automatic predict(input logic [15:0] s, output int nexp);
        int    deg;
        int    cnt;
        logic  e;
        deg  = 0;
        cnt  = 0;
        nexp = 0;
        for (int i = 0; i < 4; i++) if (((s >> (4 * i)) & 16'hF) != 16'h0) deg = i;
        for (int j = 0; j < N; j++) begin
            e = (eval_at(s, j) == 4'h0);
            if (e) cnt++;
            exp_q.push_back({4'(j), e});
            nexp++;
`ifdef CHIEN_CTRL_EARLY_EXIT_EN
            if (deg > 0 && cnt == deg) break;
`endif
        end
        sum_q.push_back({4'(cnt), (cnt != deg)});
    endtask

    // Run one polynomial; bp randomises out_ready; abort_idx >= 0 pulses reset there.
    task automatic run_poly(input logic [15:0] s, input bit bp, input int abort_idx);
        int    nexp;
        int    nbeats;
        bit    prev_stall;
        logic [3:0] prev_idx;
        logic  prev_err;
        bit    finished;
        beat_t b;
        sum_t  sm;
        nbeats     = 0;
        prev_stall = 0;
        prev_idx   = '0;
        prev_err   = 1'b0;
        finished   = 0;

        @(negedge clk);
        in_sigma = s;
        in_valid = 1'b1;
        #1;
        chk("in_ready_idle", in_ready, 1'b1);
        predict(s, nexp);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("ch_start_c1", ch_start, 1'b1);
        chk("cei_in_load", cei, 1'b0);
        chk("in_ready_load", in_ready, 1'b0);
        chk("ch_sigma_loaded", ch_sigma, s);

        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            @(negedge clk);
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (cyc == 0) chk("first_valid_c2", out_valid, 1'b1);
            chk("cei_eq_hs", cei, out_valid & out_ready);
            chk("no_start_and_cei", ch_start & cei, 1'b0);
            if (out_valid && abort_idx >= 0 && out_idx == 4'(abort_idx)) begin
                rst_n = 1'b0;
                #1;
                chk("reset_outs_zero",
                    {in_ready, ch_sigma, ch_start, cei, out_valid, out_err, out_idx,
                     done_valid, done_count, done_fail}, 32'h0);
                exp_q.delete();
                sum_q.delete();
                @(negedge clk);
                rst_n     = 1'b1;
                out_ready = 1'b0;
                #1;
                chk("in_ready_after_rst", in_ready, 1'b1);
                return;
            end
            if (out_valid) begin
                if (prev_stall) begin
                    chk("stall_idx_hold", out_idx, prev_idx);
                    chk("stall_err_hold", out_err, prev_err);
                end
                if (out_ready) begin
                    nbeats++;
                    if (exp_q.size() == 0) begin
                        chk("extra_beat_idx", out_idx, 4'hF);
                        chk("extra_beat", 1'b1, 1'b0);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_idx", out_idx, b.idx);
                        chk("beat_err", out_err, b.err);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_idx   = out_idx;
            prev_err   = out_err;
            if (done_valid) begin
                sm = sum_q.pop_front();
                chk("done_count", done_count, sm.cnt);
                chk("done_fail", done_fail, sm.fail);
                chk("beat_total", nbeats, nexp);
                chk("queue_drained", exp_q.size(), 0);
                done_ready = 1'b1;
                @(negedge clk);
                done_ready = 1'b0;
                #1;
                chk("in_ready_back", in_ready, 1'b1);
                chk("ch_sigma_held", ch_sigma, s);
                finished = 1;
            end
        end
        if (!finished) chk("search_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_sigma   = 16'h0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        done_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_outs_zero",
            {ch_sigma, ch_start, cei, out_valid, out_err, out_idx,
             done_valid, done_count, done_fail}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", in_ready, 1'b1);

        run_poly(16'h00F1, 1'b0, -1);   // single error at idx 3
        run_poly(16'h0001, 1'b0, -1);   // no error, deg 0
        run_poly(16'h00F1, 1'b1, -1);   // single error under backpressure
        run_poly(16'h0101, 1'b0, -1);   // (x+1)^2: one root, degree 2
        run_poly(16'h0000, 1'b0, -1);   // all-zero locator
        run_poly(16'h0001, 1'b0, 7);    // reset mid-search
        run_poly(16'h00F1, 1'b0, -1);   // clean restart from idx 0

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
